spi_master_ctrl: RTL and testbench

- SPI master that sits directly upstream of the SPI-slave/RAM wrapper and drives its MOSI/SS_n while sampling its MISO.
- Accepts one command per request (write-address, write-data, read-address or read-data) on a valid/ready interface and serialises it as one SS_n frame.
- For read-data frames, captures the 8-bit reply from MISO and returns it on a one-cycle response strobe.
- Replaces hand-driven bit-banging in system-level benches and on-chip command sources.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_master_ctrl_if.sv | 25 ++
 rtl/spi_shift_unit.sv | 36 +++
 rtl/spi_master_ctrl.sv | 117 +++++++++++
 tb/tb_spi_master_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI command codes, frame sizes and FSM state encoding
package spi_pkg;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_TURN,
    S_CAPTURE,
    S_GAP
  } spi_state_e;
endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - request/response handshake and SPI pins of the master
interface spi_master_ctrl_if;
  import spi_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_cmd;
  logic [DATA_BITS-1:0] req_data;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_data;
  logic                 busy;
  logic                 MOSI;
  logic                 MISO;
  logic                 SS_n;

  modport master (
    input  req_valid, req_cmd, req_data, MISO,
    output req_ready, rsp_valid, rsp_data, busy, MOSI, SS_n
  );

  modport slave (
    output req_valid, req_cmd, req_data, MISO,
    input  req_ready, rsp_valid, rsp_data, busy, MOSI, SS_n
  );
endinterface

// File: rtl/spi_shift_unit.sv
// rtl/spi_shift_unit.sv - 10-bit PISO for MOSI plus 8-bit SIPO for MISO
module spi_shift_unit
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_load_data,
  input  logic                  i_shift_tx,
  input  logic                  i_shift_rx,
  input  logic                  i_miso,
  output logic                  o_tx_bit,
  output logic [DATA_BITS-1:0]  o_rx_next
);
  logic [FRAME_BITS-1:0] r_tx;
  logic [DATA_BITS-1:0]  r_rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_load_data;
        r_rx <= '0;
      end else begin
        if (i_shift_tx) r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
        if (i_shift_rx) r_rx <= o_rx_next;
      end
    end
  end

  // Exposing the post-sample value lets the caller register the byte on the 8th sample edge.
  assign o_tx_bit  = r_tx[FRAME_BITS-1];
  assign o_rx_next = {r_rx[DATA_BITS-2:0], i_miso};
endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: one request per SS_n frame, read-data reply on a strobe
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.master bus
);
  localparam logic [3:0] BIT_LAST  = 4'(FRAME_BITS - 1);
  localparam logic [3:0] CAP_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  spi_state_e           r_state, w_state_nxt;
  logic [3:0]           r_bit_cnt, r_tmr;
  logic [1:0]           r_cmd;
  logic                 r_ss_n, r_mosi, r_req_ready, r_busy, r_rsp_valid;
  logic [DATA_BITS-1:0] r_rsp_data;

  logic                 w_load, w_shift_tx, w_shift_rx, w_rsp_fire;
  logic                 w_tx_bit, w_ss_n_nxt, w_mosi_nxt;
  logic [DATA_BITS-1:0] w_rx_next;

  spi_shift_unit u_shift (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data ({bus.req_cmd, bus.req_data}),
    .i_shift_tx  (w_shift_tx),
    .i_shift_rx  (w_shift_rx),
    .i_miso      (bus.MISO),
    .o_tx_bit    (w_tx_bit),
    .o_rx_next   (w_rx_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift_rx  = 1'b0;
    w_rsp_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_state_nxt = S_SEL;
          w_load      = 1'b1;
        end
      end
      S_SEL:   w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (r_bit_cnt == BIT_LAST)
          w_state_nxt = (r_cmd == CMD_RD_DATA) ? S_TURN : S_GAP;
      end
      S_TURN: begin
        if (r_tmr == TURN_LAST) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_shift_rx = 1'b1;
        if (r_bit_cnt == CAP_LAST) begin
          w_state_nxt = S_GAP;
          w_rsp_fire  = 1'b1;
        end
      end
      S_GAP: begin
        if (r_tmr == GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the next state, so each pin value lines up with its state's cycle.
    w_shift_tx = (w_state_nxt == S_SHIFT);
    w_ss_n_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
    w_mosi_nxt = 1'b0;
    if (w_state_nxt == S_SEL)        w_mosi_nxt = bus.req_cmd[1];
    else if (w_state_nxt == S_SHIFT) w_mosi_nxt = w_tx_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_tmr       <= '0;
      r_cmd       <= '0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_bit_cnt <= '0;
        r_tmr     <= '0;
      end else begin
        if (r_state == S_SHIFT || r_state == S_CAPTURE) r_bit_cnt <= r_bit_cnt + 4'd1;
        if (r_state == S_TURN || r_state == S_GAP)      r_tmr     <= r_tmr + 4'd1;
      end
      if (w_load) r_cmd <= bus.req_cmd;
      r_ss_n      <= w_ss_n_nxt;
      r_mosi      <= w_mosi_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) r_rsp_data <= w_rx_next;
    end
  end

  assign bus.SS_n      = r_ss_n;
  assign bus.MOSI      = r_mosi;
  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - bench for spi_master_ctrl against a frame-level slave/RAM model
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int T0 = 2;
  localparam int G0 = 1;
  localparam int T1 = 1;
  localparam int G1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if bus();
  spi_master_ctrl_if bus_sw();

  spi_master_ctrl #(.TURNAROUND(T0), .GAP_CYCLES(G0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  spi_master_ctrl #(.TURNAROUND(T1), .GAP_CYCLES(G1)) u_dut_sw (.clk(clk), .rst(rst), .bus(bus_sw));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] slv_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] slv_waddr = 8'h00;
  logic [7:0] slv_raddr = 8'h00;

  logic [10:0] mon_bits = '0;
  logic [1:0]  mon_cmd  = '0;
  logic        mon_tail = 1'b0;
  int          mon_low = 0, mon_hi = 0, mon_hi_busy = 0;
  logic [10:0] q_bits [$];
  int          q_len [$];
  logic        q_tail [$];
  int          q_hi [$];
  int          q_hi_busy [$];
  logic [7:0]  q_rsp [$];

  // Slave/RAM model: decodes each SS_n frame and answers read-data frames on MISO.
  always @(negedge clk) begin
    if (rst) begin
      mon_low = 0; mon_hi = 0; mon_hi_busy = 0; bus.MISO = 1'b0;
    end else begin
      if (bus.rsp_valid) q_rsp.push_back(bus.rsp_data);
      if (!bus.SS_n) begin
        if (mon_low == 0) begin
          q_hi.push_back(mon_hi); q_hi_busy.push_back(mon_hi_busy);
          mon_bits = '0; mon_tail = 1'b0;
        end
        mon_low++;
        if (mon_low <= 11) mon_bits = {mon_bits[9:0], bus.MOSI};
        else mon_tail = mon_tail | bus.MOSI;
        if (mon_low == 3) mon_cmd = mon_bits[1:0];
        if (mon_cmd == CMD_RD_DATA && mon_low >= 12 + T0 && mon_low <= 19 + T0)
          bus.MISO = slv_mem[slv_raddr][3'(19 + T0 - mon_low)];
        else
          bus.MISO = 1'b0;
      end else begin
        bus.MISO = 1'b0;
        if (mon_low != 0) begin
          q_bits.push_back(mon_bits); q_len.push_back(mon_low); q_tail.push_back(mon_tail);
          case (mon_bits[9:8])
            CMD_WR_ADDR: slv_waddr = mon_bits[7:0];
            CMD_WR_DATA: slv_mem[slv_waddr] = mon_bits[7:0];
            CMD_RD_ADDR: slv_raddr = mon_bits[7:0];
            default: ;
          endcase
          mon_low = 0; mon_hi = 0; mon_hi_busy = 0;
        end
        mon_hi++;
        if (bus.busy) mon_hi_busy++;
      end
    end
  end

  logic [7:0] sw_byte = 8'hA5;
  int         sw_low = 0, sw_gap_cnt = 0;
  logic       sw_in_gap = 1'b0;
  int         sw_len [$];
  int         sw_gap [$];
  logic [7:0] sw_rsp [$];

  always @(negedge clk) begin
    if (rst) begin
      sw_low = 0; sw_in_gap = 1'b0; bus_sw.MISO = 1'b0;
    end else begin
      if (bus_sw.rsp_valid) sw_rsp.push_back(bus_sw.rsp_data);
      if (!bus_sw.SS_n) begin
        sw_low++;
        if (sw_low >= 12 + T1 && sw_low <= 19 + T1) bus_sw.MISO = sw_byte[3'(19 + T1 - sw_low)];
        else bus_sw.MISO = 1'b0;
      end else begin
        bus_sw.MISO = 1'b0;
        if (sw_low != 0) begin
          sw_len.push_back(sw_low); sw_low = 0; sw_in_gap = 1'b1; sw_gap_cnt = 0;
        end
        if (sw_in_gap) begin
          if (bus_sw.req_ready) begin sw_gap.push_back(sw_gap_cnt); sw_in_gap = 1'b0; end
          else sw_gap_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 100) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 100) begin n_fail++; $display("FAIL send_ready: req_ready stayed %b, expected 1", bus.req_ready); end
    bus.req_valid = 1'b1; bus.req_cmd = c; bus.req_data = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] c, input logic [7:0] d, input logic [7:0] exp_rsp, input string tag);
    int t = 0;
    int len, exp_len;
    logic [10:0] b;
    logic tail;
    q_rsp.delete(); q_hi.delete(); q_hi_busy.delete();
    send(c, d);
    while (q_bits.size() == 0 && t < 100) begin @(posedge clk); t++; end
    exp_len = (c == CMD_RD_DATA) ? 19 + T0 : 11;
    n_checks++;
    if (q_bits.size() == 0) begin
      n_fail++; $display("FAIL %s frame_seen: got 0 frames, expected 1", tag);
    end else begin
      b = q_bits.pop_front(); len = q_len.pop_front(); tail = q_tail.pop_front();
      n_checks++;
      if (len != exp_len) begin n_fail++; $display("FAIL %s frame_len: got %0d, expected %0d", tag, len, exp_len); end
      n_checks++;
      if (c == CMD_RD_DATA) begin
        if (b[10:8] !== 3'b111) begin n_fail++; $display("FAIL %s mosi_hdr: got %b, expected 111", tag, b[10:8]); end
      end else if (b !== {c[1], c, d}) begin
        n_fail++; $display("FAIL %s mosi_bits: got %b, expected %b", tag, b, {c[1], c, d});
      end
      n_checks++;
      if (tail !== 1'b0) begin n_fail++; $display("FAIL %s mosi_tail: got %b, expected 0", tag, tail); end
      n_checks++;
      if (c == CMD_RD_DATA) begin
        if (q_rsp.size() != 1 || q_rsp[0] !== exp_rsp) begin
          n_fail++;
          $display("FAIL %s rsp: got %0d pulses data %h, expected 1 pulse data %h", tag, q_rsp.size(),
                   (q_rsp.size() > 0) ? q_rsp[0] : 8'hxx, exp_rsp);
        end
      end else if (q_rsp.size() != 0) begin
        n_fail++; $display("FAIL %s rsp_absent: got %0d pulses, expected 0", tag, q_rsp.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.SS_n, bus.MOSI, bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_data} !== {4'b1010, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got ss_n=%b mosi=%b ready=%b busy=%b rsp_valid=%b rsp_data=%h, expected 1 0 1 0 0 00",
               bus.SS_n, bus.MOSI, bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_data);
    end
    n_checks++;
    if ({bus_sw.SS_n, bus_sw.req_ready, bus_sw.busy} !== 3'b110) begin
      n_fail++; $display("FAIL reset_sw: got ss_n=%b ready=%b busy=%b, expected 1 1 0", bus_sw.SS_n, bus_sw.req_ready, bus_sw.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_addr();
    do_op(CMD_WR_ADDR, 8'h64, 8'h00, "wr_addr");
  endtask

  task automatic test_write_data();
    do_op(CMD_WR_DATA, 8'h0B, 8'h00, "wr_data");
    ref_mem[100] = 8'd11;
    n_checks++;
    if (slv_mem[100] !== 8'd11) begin n_fail++; $display("FAIL wr_data_mem: got %0d, expected 11", slv_mem[100]); end
  endtask

  task automatic test_readback();
    for (int i = 0; i < 100; i++) begin
      do_op(CMD_WR_ADDR, 8'(100 + i), 8'h00, "rb_wa");
      do_op(CMD_WR_DATA, 8'(11 * ((i % 23) + 1)), 8'h00, "rb_wd");
      ref_mem[100 + i] = 8'(11 * ((i % 23) + 1));
    end
    for (int i = 0; i < 100; i++) begin
      do_op(CMD_RD_ADDR, 8'(100 + i), 8'h00, "rb_ra");
      do_op(CMD_RD_DATA, 8'h00, 8'(11 * ((i % 23) + 1)), "rb_rd");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_op(CMD_WR_ADDR, a, 8'h00, "rand_wa");
        do_op(CMD_WR_DATA, d, 8'h00, "rand_wd");
        ref_mem[a] = d;
      end else begin
        do_op(CMD_RD_ADDR, a, 8'h00, "rand_ra");
        do_op(CMD_RD_DATA, d, ref_mem[a], "rand_rd");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] cmds [4];
    logic [7:0] dats [4];
    logic [7:0] a, d;
    int t;
    a = 8'($urandom_range(0, 255));
    d = 8'($urandom_range(1, 255));
    cmds = '{CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA};
    dats = '{a, d, a, 8'h5A};
    q_bits.delete(); q_len.delete(); q_tail.delete(); q_hi.delete(); q_hi_busy.delete(); q_rsp.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_cmd = cmds[k]; bus.req_data = dats[k];
      t = 0;
      while (!bus.req_ready && t < 100) begin @(negedge clk); t++; end
      n_checks++;
      if (t >= 100) begin n_fail++; $display("FAIL b2b_ready%0d: req_ready stayed 0, expected 1", k); end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    ref_mem[a] = d;
    t = 0;
    while (q_bits.size() < 4 && t < 200) begin @(posedge clk); t++; end
    repeat (30) @(posedge clk);
    n_checks++;
    if (q_bits.size() != 4) begin
      n_fail++; $display("FAIL b2b_frames: got %0d frames, expected 4", q_bits.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (k == 3) begin
          if (q_bits[k][10:8] !== 3'b111 || q_len[k] != 19 + T0) begin
            n_fail++; $display("FAIL b2b_frame3: got hdr %b len %0d, expected 111 len %0d", q_bits[k][10:8], q_len[k], 19 + T0);
          end
        end else if (q_bits[k] !== {cmds[k][1], cmds[k], dats[k]} || q_len[k] != 11) begin
          n_fail++;
          $display("FAIL b2b_frame%0d: got %b len %0d, expected %b len 11", k, q_bits[k], q_len[k], {cmds[k][1], cmds[k], dats[k]});
        end
        if (k > 0) begin
          n_checks++;
          if (q_hi[k] != G0 + 1 || q_hi_busy[k] != G0) begin
            n_fail++;
            $display("FAIL b2b_gap%0d: got high %0d (gap %0d), expected high %0d (gap %0d)", k, q_hi[k], q_hi_busy[k], G0 + 1, G0);
          end
        end
      end
    end
    n_checks++;
    if (q_rsp.size() != 1 || q_rsp[0] !== d) begin
      n_fail++;
      $display("FAIL b2b_rsp: got %0d pulses data %h, expected 1 pulse data %h", q_rsp.size(), (q_rsp.size() > 0) ? q_rsp[0] : 8'hxx, d);
    end
    q_bits.delete(); q_len.delete(); q_tail.delete();
  endtask

  task automatic test_reset_midframe();
    int n, t = 0;
    send(CMD_RD_DATA, 8'hFF);
    n = bus.SS_n ? 0 : 1;
    while (n < 7 && t < 50) begin
      @(negedge clk); t++;
      if (!bus.SS_n) n++;
    end
    n_checks++;
    if (n != 7) begin n_fail++; $display("FAIL rstmid_reach: got %0d low cycles, expected 7", n); end
    rst = 1'b1;
    q_rsp.delete();
    @(negedge clk);
    n_checks++;
    if ({bus.SS_n, bus.MOSI, bus.req_ready, bus.rsp_valid, bus.rsp_data} !== {4'b1010, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_state: got ss_n=%b mosi=%b ready=%b rsp_valid=%b rsp_data=%h, expected 1 0 1 0 00",
               bus.SS_n, bus.MOSI, bus.req_ready, bus.rsp_valid, bus.rsp_data);
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (q_rsp.size() != 0 || q_bits.size() != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got %0d rsp %0d frames, expected 0 0", q_rsp.size(), q_bits.size());
    end
  endtask

  task automatic test_param_sweep();
    int t = 0;
    sw_len.delete(); sw_gap.delete(); sw_rsp.delete();
    @(negedge clk);
    while (!bus_sw.req_ready && t < 100) begin @(negedge clk); t++; end
    bus_sw.req_valid = 1'b1; bus_sw.req_cmd = CMD_RD_DATA; bus_sw.req_data = 8'h3C;
    @(negedge clk);
    bus_sw.req_valid = 1'b0;
    t = 0;
    while (sw_gap.size() == 0 && t < 200) begin @(posedge clk); t++; end
    n_checks++;
    if (sw_gap.size() == 0 || sw_len.size() == 0) begin
      n_fail++; $display("FAIL sweep_done: got %0d frames, expected 1", sw_len.size());
    end else begin
      n_checks++;
      if (sw_len[0] != 19 + T1) begin n_fail++; $display("FAIL sweep_len: got %0d, expected %0d", sw_len[0], 19 + T1); end
      n_checks++;
      if (sw_gap[0] != G1) begin n_fail++; $display("FAIL sweep_gap: got %0d, expected %0d", sw_gap[0], G1); end
    end
    n_checks++;
    if (sw_rsp.size() != 1 || sw_rsp[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL sweep_rsp: got %0d pulses data %h, expected 1 pulse data a5", sw_rsp.size(), (sw_rsp.size() > 0) ? sw_rsp[0] : 8'hxx);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_cmd = 2'b00; bus.req_data = 8'h00;
    bus_sw.req_valid = 1'b0; bus_sw.req_cmd = 2'b00; bus_sw.req_data = 8'h00;
    test_reset();
    test_write_addr();
    test_write_data();
    test_readback();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end
endmodule
